// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the synchronous-read RAM request controller and its response FIFO.
package ram_ctrl_pkg;

    localparam int unsigned AWIDTH_DEF    = 3;
    localparam int unsigned DWIDTH_DEF    = 32;
    localparam int unsigned RSP_DEPTH_MIN = 2;

    // Bits needed to index n items; never less than 1 so widths stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous FIFO holding RAM read responses; any depth, head exposed combinationally.
module ram_rsp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) wptr_d = ptr_inc(wptr_q);
        if (pop_i)  rptr_d = ptr_inc(rptr_q);
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/ram_req_ctrl.sv
// Request-side controller for a synchronous-read single-port RAM: one access per cycle,
// in-order read responses with the one-cycle RAM latency absorbed.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH    = AWIDTH_DEF,
    parameter int unsigned DWIDTH    = DWIDTH_DEF,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam int unsigned OccW = clog2(RSP_DEPTH + 1);

    if (RSP_DEPTH < RSP_DEPTH_MIN) begin : g_depth_check
        $error("ram_req_ctrl: RSP_DEPTH must be at least RSP_DEPTH_MIN");
    end

    logic              acc;
    logic              inflight_q, inflight_d;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [OccW-1:0]   fifo_count;
    logic [OccW-1:0]   occ;
    logic [DWIDTH-1:0] fifo_head;

    assign acc        = req_valid & req_ready;
    assign inflight_d = acc & ~req_we;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) inflight_q <= 1'b0;
        else          inflight_q <= inflight_d;
    end

    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;
    assign ram_we   = acc & req_we;

    // Counting the read in flight reserves its FIFO slot before the data arrives.
    assign occ       = fifo_count + OccW'(inflight_q);
    assign req_ready = reset_n & (occ < OccW'(RSP_DEPTH));

    assign rsp_valid = ~fifo_empty;
    assign fifo_pop  = rsp_valid & rsp_ready;
    // Storage is not reset, so the head is masked while reset is held.
    assign rsp_rdata = reset_n ? fifo_head : '0;

    ram_rsp_fifo #(
        .Depth (RSP_DEPTH),
        .Width (DWIDTH),
        .CntW  (OccW)
    ) u_rsp_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (inflight_q),
        .wdata_i (ram_dout),
        .pop_i   (fifo_pop),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed and random bench for ram_req_ctrl paired with a registered-address RAM model.
module tb_ram_req_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [2:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    ram_req_ctrl #(
        .AWIDTH    (3),
        .DWIDTH    (32),
        .RSP_DEPTH (3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    // Synchronous-read RAM: address registered every cycle, no reset on contents.
    logic [31:0] ram_mem [8];
    logic [2:0]  ram_addr_q;
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_addr_q <= ram_addr;
    end
    assign ram_dout = ram_mem[ram_addr_q];

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: memory image plus queue of expected read responses.
    logic [31:0] model_mem [8];
    logic [31:0] exp_q [$];

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            check_eq("ready_rule", 32'(req_ready), 32'(exp_q.size() < 3));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check_eq("rsp_spurious", 32'(rsp_valid), 32'd0);
                else                   check_eq("rsp_data", rsp_rdata, exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                if (req_we) model_mem[req_addr] = req_wdata;
                else        exp_q.push_back(model_mem[req_addr]);
            end
        end
    end

    int accepted;

    initial begin
        clock     = 1'b0;
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd0;
        req_wdata = 32'hDEAD_BEEF;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
        #2;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        reset_n   = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_eq("ready_after_rst", 32'(req_ready), 32'd1);

        // Fill all addresses, then read them back-to-back.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 3'(i);
            req_wdata = 32'hA0 + 32'(i);
            #1;
            if (i == 0) check_eq("wr_ram_we", 32'(ram_we), 32'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_addr  = 3'(i);
            end else begin
                req_valid = 1'b0;
            end
            if (i == 0) begin
                #1;
                check_eq("rd_ram_we", 32'(ram_we), 32'd0);
            end
            tick();
            check_eq("rd_valid", 32'(rsp_valid), 32'((i >= 1) && (i <= 8)));
            check_eq("rd_ready", 32'(req_ready), 32'd1);
            if (i >= 1 && i <= 8) check_eq("rd_data", rsp_rdata, 32'hA0 + 32'(i - 1));
        end

        // Read the cycle after a write to the same address.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 32'h1234;
        tick();
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("raw_valid", 32'(rsp_valid), 32'd1);
        check_eq("raw_data", rsp_rdata, 32'h1234);
        tick();

        // Write the cycle after a read to the same address.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 32'h55;
        tick();
        req_we = 1'b0;
        tick();
        req_we = 1'b1; req_wdata = 32'h99;
        tick();
        check_eq("war_old", rsp_rdata, 32'h55);
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("war_new", rsp_rdata, 32'h99);
        tick();

        // Backpressure: only RSP_DEPTH reads fit while the consumer stalls.
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 3'(i);
            if (req_ready) accepted++;
            tick();
        end
        check_eq("bp_accepts", 32'(accepted), 32'd3);
        check_eq("bp_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check_eq("bp_d0", rsp_rdata, 32'hA0);
        tick();
        check_eq("bp_ready_back", 32'(req_ready), 32'd1);
        check_eq("bp_d1", rsp_rdata, 32'hA1);
        tick();
        check_eq("bp_d2", rsp_rdata, 32'h99);
        tick();
        check_eq("bp_empty", 32'(rsp_valid), 32'd0);

        // Reset with one read in flight and two responses buffered.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = (i == 2) ? 3'd6 : 3'(i + 3);
            tick();
        end
        check_eq("mr_pre_valid", 32'(rsp_valid), 32'd1);
        check_eq("mr_pre_ready", 32'(req_ready), 32'd0);
        req_we    = 1'b1;
        req_addr  = 3'd1;
        req_wdata = 32'hFFFF;
        reset_n   = 1'b0;
        #1;
        check_eq("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mr_req_ready", 32'(req_ready), 32'd0);
        check_eq("mr_ram_we", 32'(ram_we), 32'd0);
        check_eq("mr_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        reset_n   = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_eq("mr_ready_rel", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mr_no_stale", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("mr_read", rsp_rdata, 32'hA7);
        tick();

        // Random mixed traffic, checked by the negedge scoreboard.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 3'($urandom_range(0, 7));
            req_wdata = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) tick();
        check_eq("drain_empty", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
